// File: rtl/lc3b_types.sv
// Shared LC-3b types for the MEM stage: word/register/opcode widths, the access FSM
// state enum and opcode classification helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [3:0]  lc3b_opcode;
  typedef logic [1:0]  lc3b_be;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10
  } mem_stage_state_t;

  localparam lc3b_opcode OP_LDB = 4'h2;
  localparam lc3b_opcode OP_STB = 4'h3;
  localparam lc3b_opcode OP_LDR = 4'h6;
  localparam lc3b_opcode OP_STR = 4'h7;
  localparam lc3b_opcode OP_LDI = 4'hA;
  localparam lc3b_opcode OP_STI = 4'hB;

  function automatic logic is_mem_op(input lc3b_opcode op);
    case (op)
      OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI: is_mem_op = 1'b1;
      default:                                        is_mem_op = 1'b0;
    endcase
  endfunction

  // STI counts as a store even though its first access is a pointer read.
  function automatic logic is_store(input lc3b_opcode op);
    case (op)
      OP_STB, OP_STR, OP_STI: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_indirect(input lc3b_opcode op);
    case (op)
      OP_LDI, OP_STI: is_indirect = 1'b1;
      default:        is_indirect = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// Store data/byte-enable formatting: STB replicates the low byte into both lanes and
// selects the lane by address bit 0; every other access is a full word.
module store_align
  import lc3b_types::*;
(
  input  logic [3:0]  opcode,
  input  logic        addr_lsb,
  input  logic [15:0] src,
  output logic [15:0] wdata,
  output logic [1:0]  byte_enable
);

  // Lane selection for byte stores, full word otherwise.
  always_comb begin
    wdata       = src;
    byte_enable = 2'b11;
    if (opcode == OP_STB) begin
      wdata       = {src[7:0], src[7:0]};
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
    end else begin
      wdata       = src;
      byte_enable = 2'b11;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: data-memory access FSM (incl. LDI/STI indirection) feeding MEM/WB.
// Optional stall-cycle counter enabled by defining MEM_ACCESS_STAGE_PERF_EN.
module mem_access_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_opcode,
  input  logic [15:0] in_pc,
  input  logic [15:0] in_pc_br,
  input  logic [15:0] in_alu_out,
  input  logic [15:0] in_src_data,
  input  logic [2:0]  in_dest,
  input  logic        in_load_cc,
  input  logic        in_load_regfile,
  input  logic [2:0]  in_regfilemux_sel,
  input  logic        flush,
  output logic        stall,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        wb_valid,
  output logic [15:0] wb_pc,
  output logic [15:0] wb_pc_br,
  output logic [15:0] wb_dmem_address,
  output logic [15:0] wb_mem_rdata,
  output logic [15:0] wb_alu_out,
  output logic [2:0]  wb_dest,
  output logic [3:0]  wb_opcode,
  output logic        wb_load_cc,
  output logic        wb_load_regfile,
  output logic [2:0]  wb_regfilemux_sel,
  output logic [15:0] perf_stall_cycles
);

  mem_stage_state_t state;
  logic        flushed_r;
  logic        mem_op_s, store_s, ind_s, flush_any_s;
  logic        issue_s, pass_s, final_s, retire_s, stall_s;
  logic [15:0] align_wdata_s;
  logic [1:0]  align_be_s;

  assign mem_op_s    = is_mem_op(in_opcode);
  assign store_s     = is_store(in_opcode);
  assign ind_s       = is_indirect(in_opcode);
  // A flush seen in any earlier access cycle is remembered until the access completes.
  assign flush_any_s = flush | flushed_r;

  store_align u_store_align (
    .opcode      (in_opcode),
    .addr_lsb    (in_alu_out[0]),
    .src         (in_src_data),
    .wdata       (align_wdata_s),
    .byte_enable (align_be_s)
  );

  // Decide whether this cycle's response ends the instruction.
  always_comb begin
    final_s = 1'b0;
    case (state)
      IDLE:    final_s = 1'b0;
      ACC1:    final_s = dmem_resp & (~ind_s | flush_any_s);
      ACC2:    final_s = dmem_resp;
      default: final_s = 1'b0;
    endcase
  end

  assign issue_s  = (state == IDLE) & in_valid & ~flush & mem_op_s;
  assign pass_s   = (state == IDLE) & in_valid & ~flush & ~mem_op_s;
  assign retire_s = pass_s | (final_s & ~flush_any_s);
  assign stall_s  = issue_s | ((state != IDLE) & ~final_s);
  assign stall    = stall_s & ~rst;

  // Access FSM; the memory request is registered and held until its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      flushed_r        <= 1'b0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= 16'h0000;
      dmem_wdata       <= 16'h0000;
      dmem_byte_enable <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          flushed_r <= 1'b0;
          if (issue_s) begin
            state            <= ACC1;
            dmem_read        <= ~store_s | ind_s;
            dmem_write       <= store_s & ~ind_s;
            dmem_address     <= in_alu_out;
            dmem_wdata       <= align_wdata_s;
            dmem_byte_enable <= align_be_s;
          end else begin
            state <= IDLE;
          end
        end
        ACC1, ACC2: begin
          if (final_s) begin
            state            <= IDLE;
            flushed_r        <= 1'b0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= 16'h0000;
            dmem_wdata       <= 16'h0000;
            dmem_byte_enable <= 2'b00;
          end else if (dmem_resp) begin
            // Pointer fetched: second access goes to the returned address.
            state        <= ACC2;
            dmem_address <= dmem_rdata;
            dmem_read    <= ~store_s;
            dmem_write   <= store_s;
          end else begin
            flushed_r <= flush_any_s;
          end
        end
        default: begin
          state            <= IDLE;
          flushed_r        <= 1'b0;
          dmem_read        <= 1'b0;
          dmem_write       <= 1'b0;
          dmem_address     <= 16'h0000;
          dmem_wdata       <= 16'h0000;
          dmem_byte_enable <= 2'b00;
        end
      endcase
    end
  end

  // MEM/WB register: loads on retirement, otherwise carries a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid          <= 1'b0;
      wb_load_cc        <= 1'b0;
      wb_load_regfile   <= 1'b0;
      wb_pc             <= 16'h0000;
      wb_pc_br          <= 16'h0000;
      wb_dmem_address   <= 16'h0000;
      wb_mem_rdata      <= 16'h0000;
      wb_alu_out        <= 16'h0000;
      wb_dest           <= 3'b000;
      wb_opcode         <= 4'h0;
      wb_regfilemux_sel <= 3'b000;
    end else begin
      wb_valid        <= retire_s;
      wb_load_cc      <= retire_s & in_load_cc;
      wb_load_regfile <= retire_s & in_load_regfile;
      if (retire_s) begin
        wb_pc             <= in_pc;
        wb_pc_br          <= in_pc_br;
        wb_alu_out        <= in_alu_out;
        wb_dest           <= in_dest;
        wb_opcode         <= in_opcode;
        wb_regfilemux_sel <= in_regfilemux_sel;
        wb_dmem_address   <= pass_s ? 16'h0000 : dmem_address;
        wb_mem_rdata      <= (pass_s | store_s) ? 16'h0000 : dmem_rdata;
      end
    end
  end

`ifdef MEM_ACCESS_STAGE_PERF_EN
  logic [15:0] perf_r;

  // Saturating count of cycles in which upstream is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_r <= 16'h0000;
    end else if (stall_s && (perf_r != 16'hFFFF)) begin
      perf_r <= perf_r + 16'h0001;
    end
  end

  assign perf_stall_cycles = perf_r;
`else
  assign perf_stall_cycles = 16'h0000;
`endif

endmodule
